// File: rtl/dcpu16_mbus.sv
// Two-master (FS, AB) to one-slave (MM) bus arbiter for the DCPU16 core.
// Round-robin grant, one transaction at a time, optional ack timeout with bus-error pulse.
module dcpu16_mbus #(
  parameter int unsigned TOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fs_adr,
  input  logic        fs_stb,
  input  logic        fs_wre,
  input  logic [15:0] fs_dto,
  output logic [15:0] fs_dti,
  output logic        fs_ack,
  input  logic [15:0] ab_adr,
  input  logic        ab_stb,
  input  logic        ab_wre,
  input  logic [15:0] ab_dto,
  output logic [15:0] ab_dti,
  output logic        ab_ack,
  output logic [15:0] mm_adr,
  output logic        mm_stb,
  output logic        mm_wre,
  output logic [15:0] mm_dto,
  input  logic [15:0] mm_dti,
  input  logic        mm_ack,
  output logic        err
);

  localparam int unsigned CntW = (TOUT < 1) ? 1 : $clog2(TOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'((TOUT == 0) ? 0 : TOUT - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGfs  = 2'd1,
    StGab  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;  // 1: AB was granted last
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic gnt_fs;
  logic g_stb;
  logic tout_hit;
  logic done;

  assign gnt_fs   = (state_q == StGfs);
  assign g_stb    = gnt_fs ? fs_stb : ab_stb;
  assign tout_hit = (TOUT != 0) && (state_q != StIdle) && g_stb && !mm_ack &&
                    (cnt_q == CntLast);
  assign done     = g_stb && (mm_ack || tout_hit);
  assign err      = err_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    mm_adr  = 16'h0000;
    mm_stb  = 1'b0;
    mm_wre  = 1'b0;
    mm_dto  = 16'h0000;
    fs_ack  = 1'b0;
    ab_ack  = 1'b0;
    fs_dti  = 16'h0000;
    ab_dti  = 16'h0000;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fs_stb && (!ab_stb || last_q)) begin
          state_d = StGfs;
          last_d  = 1'b0;
        end else if (ab_stb) begin
          state_d = StGab;
          last_d  = 1'b1;
        end
      end
      StGfs, StGab: begin
        mm_adr = gnt_fs ? fs_adr : ab_adr;
        mm_wre = gnt_fs ? fs_wre : ab_wre;
        mm_dto = gnt_fs ? fs_dto : ab_dto;
        mm_stb = g_stb && !tout_hit;
        fs_dti = mm_dti;
        ab_dti = mm_dti;
        // A dropped strobe aborts: no ack even if mm_ack shows up this cycle.
        if (gnt_fs) begin
          fs_ack = done;
          if (tout_hit) fs_dti = 16'h0000;
        end else begin
          ab_ack = done;
          if (tout_hit) ab_dti = 16'h0000;
        end
        if (!g_stb || mm_ack || tout_hit) begin
          state_d = StIdle;
          cnt_d   = '0;
          err_d   = tout_hit;
        end else if (TOUT != 0) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dcpu16_mbus.sv
// Directed, table-driven check of dcpu16_mbus (TOUT=4): grants, round-robin, abort,
// timeout and reset recovery.
module tb_dcpu16_mbus;

  logic        clk;
  logic        rst;
  logic [15:0] fs_adr, fs_dto, fs_dti;
  logic        fs_stb, fs_wre, fs_ack;
  logic [15:0] ab_adr, ab_dto, ab_dti;
  logic        ab_stb, ab_wre, ab_ack;
  logic [15:0] mm_adr, mm_dto, mm_dti;
  logic        mm_stb, mm_wre, mm_ack;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  dcpu16_mbus #(.TOUT(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .fs_adr (fs_adr),
    .fs_stb (fs_stb),
    .fs_wre (fs_wre),
    .fs_dto (fs_dto),
    .fs_dti (fs_dti),
    .fs_ack (fs_ack),
    .ab_adr (ab_adr),
    .ab_stb (ab_stb),
    .ab_wre (ab_wre),
    .ab_dto (ab_dto),
    .ab_dti (ab_dti),
    .ab_ack (ab_ack),
    .mm_adr (mm_adr),
    .mm_stb (mm_stb),
    .mm_wre (mm_wre),
    .mm_dto (mm_dto),
    .mm_dti (mm_dti),
    .mm_ack (mm_ack),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in:  {fs_stb, fs_wre, fs_adr, fs_dto, ab_stb, ab_wre, ab_adr, ab_dto, mm_ack, mm_dti}
  // exp: {mm_stb, mm_adr, mm_wre, mm_dto, fs_ack, fs_dti, ab_ack, ab_dti, err}
  typedef struct {
    logic [84:0] in;
    logic [68:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  localparam logic [68:0] OIdle = '0;

  function automatic logic [84:0] xi(logic fs, logic fw, logic [15:0] fa, logic [15:0] fd,
                                     logic as, logic aw, logic [15:0] aa, logic [15:0] ad,
                                     logic ma, logic [15:0] md);
    return {fs, fw, fa, fd, as, aw, aa, ad, ma, md};
  endfunction

  function automatic logic [68:0] xo(logic ms, logic [15:0] ma, logic mw, logic [15:0] md,
                                     logic fk, logic [15:0] fd, logic ak, logic [15:0] ad,
                                     logic e);
    return {ms, ma, mw, md, fk, fd, ak, ad, e};
  endfunction

  task automatic add(input string nm, input logic [84:0] i, input logic [68:0] e);
    vec_t v;
    v.in   = i;
    v.exp  = e;
    v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [68:0] e);
    logic [68:0] act;
    act = {mm_stb, mm_adr, mm_wre, mm_dto, fs_ack, fs_dti, ab_ack, ab_dti, err};
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, e);
    end
  endtask

  task automatic drive(input logic [84:0] i);
    {fs_stb, fs_wre, fs_adr, fs_dto, ab_stb, ab_wre, ab_adr, ab_dto, mm_ack, mm_dti} = i;
  endtask

  logic [84:0] in_both;

  initial begin
    // Simultaneous requests right after reset: FS wins, AB follows after one IDLE cycle.
    add("sim_idle", xi(1, 1, 16'h0010, 16'h1234, 1, 0, 16'h0020, 0, 0, 0), OIdle);
    add("sim_fs",   xi(1, 1, 16'h0010, 16'h1234, 1, 0, 16'h0020, 0, 1, 0),
        xo(1, 16'h0010, 1, 16'h1234, 1, 0, 0, 0, 0));
    add("sim_gap",  xi(0, 0, 0, 0, 1, 0, 16'h0020, 0, 0, 0), OIdle);
    add("sim_ab",   xi(0, 0, 0, 0, 1, 0, 16'h0020, 0, 1, 16'h5A5A),
        xo(1, 16'h0020, 0, 0, 0, 16'h5A5A, 1, 16'h5A5A, 0));
    add("sim_end",  xi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), OIdle);
    // Continuous contention: alternation FS, AB, ...; mm_ack in IDLE is ignored.
    for (int k = 0; k < 6; k++) begin
      logic [15:0] d;
      d = 16'(k + 1);
      in_both = xi(1, 0, 16'h1000, 0, 1, 0, 16'h2000, 0, (k == 0), (k == 0) ? 16'hFFFF : 0);
      add($sformatf("cont_idle%0d", k), in_both, OIdle);
      in_both = xi(1, 0, 16'h1000, 0, 1, 0, 16'h2000, 0, 1, d);
      if (k % 2 == 0)
        add($sformatf("cont_fs%0d", k), in_both, xo(1, 16'h1000, 0, 0, 1, d, 0, d, 0));
      else
        add($sformatf("cont_ab%0d", k), in_both, xo(1, 16'h2000, 0, 0, 0, d, 1, d, 0));
    end
    add("cont_end", xi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), OIdle);
    // Single FS read, zero wait.
    add("rd_idle", xi(1, 0, 16'h0100, 0, 0, 0, 0, 0, 0, 0), OIdle);
    add("rd_ack",  xi(1, 0, 16'h0100, 0, 0, 0, 0, 0, 1, 16'hBEEF),
        xo(1, 16'h0100, 0, 0, 1, 16'hBEEF, 0, 16'hBEEF, 0));
    add("rd_done", xi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), OIdle);
    // Abort: strobe drops after two waits with mm_ack in the drop cycle.
    add("abt_req",  xi(1, 0, 16'h0300, 0, 0, 0, 0, 0, 0, 0), OIdle);
    add("abt_w1",   xi(1, 0, 16'h0300, 0, 0, 0, 0, 0, 0, 0), xo(1, 16'h0300, 0, 0, 0, 0, 0, 0, 0));
    add("abt_w2",   xi(1, 0, 16'h0300, 0, 0, 0, 0, 0, 0, 0), xo(1, 16'h0300, 0, 0, 0, 0, 0, 0, 0));
    add("abt_drop", xi(0, 0, 16'h0300, 0, 0, 0, 0, 0, 1, 0), xo(0, 16'h0300, 0, 0, 0, 0, 0, 0, 0));
    add("abt_idle", xi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), OIdle);
    // Timeout: AB read never acked, forced ack in the 4th granted cycle, err after.
    add("to_req", xi(0, 0, 0, 0, 1, 0, 16'h0400, 0, 0, 0), OIdle);
    for (int k = 1; k <= 3; k++)
      add($sformatf("to_w%0d", k), xi(0, 0, 0, 0, 1, 0, 16'h0400, 0, 0, 0),
          xo(1, 16'h0400, 0, 0, 0, 0, 0, 0, 0));
    add("to_hit", xi(0, 0, 0, 0, 1, 0, 16'h0400, 0, 0, 16'hDEAD),
        xo(0, 16'h0400, 0, 0, 0, 16'hDEAD, 1, 16'h0000, 0));
    add("to_err", xi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), xo(0, 0, 0, 0, 0, 0, 0, 0, 1));
    add("to_clr", xi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), OIdle);
    // A real ack in the deadline cycle wins over the timeout.
    add("dl_req", xi(0, 0, 0, 0, 1, 1, 16'h0500, 16'h4242, 0, 0), OIdle);
    for (int k = 1; k <= 3; k++)
      add($sformatf("dl_w%0d", k), xi(0, 0, 0, 0, 1, 1, 16'h0500, 16'h4242, 0, 0),
          xo(1, 16'h0500, 1, 16'h4242, 0, 0, 0, 0, 0));
    add("dl_ack", xi(0, 0, 0, 0, 1, 1, 16'h0500, 16'h4242, 1, 16'h1111),
        xo(1, 16'h0500, 1, 16'h4242, 0, 16'h1111, 1, 16'h1111, 0));
    add("dl_next", xi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), OIdle);

    // Reset: outputs stay 0 even with requests and mm_ack present.
    rst = 1'b0;
    drive(xi(1, 1, 16'hAAAA, 16'h5555, 1, 1, 16'hBBBB, 16'h6666, 1, 16'hCCCC));
    #2 chk("rst_out", OIdle);
    drive('0);
    #5 rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      #3 chk(vecs[i].name, vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // Reset mid-GAB with a wait state pending.
    drive(xi(0, 0, 0, 0, 1, 0, 16'h0600, 0, 0, 0));
    @(posedge clk);
    #1;
    #3 chk("mid_gab", xo(1, 16'h0600, 0, 0, 0, 0, 0, 0, 0));
    #1;
    rst = 1'b0;
    mm_ack = 1'b1;
    mm_dti = 16'hABCD;
    #1 chk("mid_rst", OIdle);
    drive(xi(1, 0, 16'h0700, 0, 1, 0, 16'h0600, 0, 0, 0));
    @(posedge clk);
    #1 chk("rst_hold", OIdle);
    rst = 1'b1;
    @(posedge clk);
    #1;
    #3 chk("post_rst_fs", xo(1, 16'h0700, 0, 0, 0, 0, 0, 0, 0));
    mm_ack = 1'b1;
    mm_dti = 16'h0707;
    #1 chk("post_rst_ack", xo(1, 16'h0700, 0, 0, 1, 16'h0707, 0, 16'h0707, 0));
    @(posedge clk);
    #1;
    drive(xi(0, 0, 0, 0, 1, 0, 16'h0600, 0, 0, 0));
    #3 chk("post_rst_gap", OIdle);
    @(posedge clk);
    #1;
    #3 chk("post_rst_ab", xo(1, 16'h0600, 0, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
